// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - VGA timing generator with registered sprite/maze colour arbitration
module vga_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_en,
  output logic       frame_start,
  input  logic       pac_valid,
  input  logic [5:0] pac_rgb,
  input  logic       ghost_valid,
  input  logic [5:0] ghost_rgb,
  input  logic [5:0] maze_rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       collision
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       div;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       hs_win;
  logic       vs_win;
  logic [5:0] rgb_next;
  logic [5:0] rgb_q;

  assign pix_en      = div;
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign frame_start = div && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Stage-0 decode of the pixel currently addressed by the counters
  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_win = (h_cnt >= HS_START) && (h_cnt <= HS_END);
  assign vs_win = (v_cnt >= VS_START) && (v_cnt <= VS_END);

  assign r = rgb_q[5:4];
  assign g = rgb_q[3:2];
  assign b = rgb_q[1:0];

  // Fixed-priority colour pick: ghost over Pac-Man over maze, black in blanking
  always_comb begin
    rgb_next = 6'h00;
    if (active) begin
      if (ghost_valid)    rgb_next = ghost_rgb;
      else if (pac_valid) rgb_next = pac_rgb;
      else                rgb_next = maze_rgb;
    end
  end

  // Pixel-rate divider: pix_en is high on every second clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= 1'b0;
    else        div <= ~div;
  end

  // Horizontal/vertical raster counters, advanced once per pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (div) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage-1 registers: syncs delayed one pixel so they line up with colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb_q <= 6'h00;
    end else if (div) begin
      hsync <= ~hs_win;
      vsync <= ~vs_win;
      rgb_q <= rgb_next;
    end
  end

  // Sticky overlap flag; the frame-start clear takes precedence over a set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else if (div) begin
      if (frame_start)                            collision <= 1'b0;
      else if (active && pac_valid && ghost_valid) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb/tb_vga_frame_ctrl.sv - randomized self-checking bench for vga_frame_ctrl
module tb_vga_frame_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       pix_en, frame_start;
  logic       pac_valid, ghost_valid;
  logic [5:0] pac_rgb, ghost_rgb, maze_rgb;
  logic       hsync, vsync, collision;
  logic [1:0] r, g, b;

  vga_frame_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_en(pix_en),
    .frame_start(frame_start), .pac_valid(pac_valid), .pac_rgb(pac_rgb),
    .ghost_valid(ghost_valid), .ghost_rgb(ghost_rgb), .maze_rgb(maze_rgb),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .collision(collision)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int mode = 1;  // 0 random, 1 maze only, 2 hit in active area, 3 hit in blanking

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model state: edges since release, and the pixel captured at the next pixel edge
  int n, p, h, v, pq, ph, pvv;
  logic pe, fs, act;
  logic exp_hs, exp_vs, exp_coll;
  logic [5:0] exp_rgb;
  logic pend, rp, rg;
  logic [5:0] rprgb, rgrgb, rmrgb;
  logic arm2, arm3, pure3;
  int cnt_clk, hs_low, vs_low, on_cnt;
  logic full, pure1, prev_hs, prev_vs;

  // Per-cycle reference model and comparison, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      n = 0; exp_hs = 1; exp_vs = 1; exp_rgb = 0; exp_coll = 0; pend = 0;
      arm2 = 0; arm3 = 0; pure3 = 0; full = 0; pure1 = 0; prev_hs = 1; prev_vs = 1;
      cnt_clk = 0; hs_low = 0; vs_low = 0; on_cnt = 0;
    end else begin
      n++;
      if (pend) begin
        ph = pq % HT; pvv = (pq / HT) % VT;
        act = (ph < HA) && (pvv < VA);
        exp_hs = !(ph >= HA + HF && ph < HA + HF + HS);
        exp_vs = !(pvv >= VA + VF && pvv < VA + VF + VS);
        exp_rgb = !act ? 6'h00 : rg ? rgrgb : rp ? rprgb : rmrgb;
        if (pq % FT == 0) exp_coll = 0;
        else if (act && rp && rg) exp_coll = 1;
        pend = 0;
        if (arm2) begin
          chk("hit_rgb_pin", {r, g, b}, 6'h30);
          chk("hit_coll_pin", collision, 1'b1);
          arm2 = 0;
        end
        if (arm3) begin
          chk("blank_rgb_pin", {r, g, b}, 6'h00);
          chk("blank_coll_pin", collision, 1'b0);
          arm3 = 0;
        end
      end
      p = n / 2; h = p % HT; v = (p / HT) % VT;
      pe = n[0];
      fs = pe && h == 0 && v == 0;
      chk("pix_en", pix_en, pe);
      chk("pix_x", pix_x, h);
      chk("pix_y", pix_y, v);
      chk("frame_start", frame_start, fs);
      chk("hsync", hsync, exp_hs);
      chk("vsync", vsync, exp_vs);
      chk("rgb", {r, g, b}, exp_rgb);
      chk("collision", collision, exp_coll);

      if (prev_hs && !hsync) chk("hsync_first_x", pix_x, HA + HF + 1);
      if (prev_vs && !vsync) chk("vsync_first_xy", {pix_y, pix_x}, {10'(VA + VF), 10'd1});
      prev_hs = hsync; prev_vs = vsync;

      if (frame_start) begin
        if (full) begin
          chk("frame_clks", cnt_clk, 2 * 30 * 17);
          chk("hsync_low_clks", hs_low, 2 * 6 * 17);
          chk("vsync_low_clks", vs_low, 2 * 2 * 30);
          if (pure1) chk("maze_on_clks", on_cnt, 2 * 16 * 10);
        end
        cnt_clk = 0; hs_low = 0; vs_low = 0; on_cnt = 0;
        full = 1; pure1 = (mode == 1); pure3 = (mode == 3);
      end
      if (mode != 1) pure1 = 0;
      if (mode != 3) pure3 = 0;
      cnt_clk++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if ({r, g, b} == 6'h3F) on_cnt++;

      case (mode)
        0: begin
          pac_valid = 1'($urandom); ghost_valid = 1'($urandom);
          pac_rgb = 6'($urandom); ghost_rgb = 6'($urandom); maze_rgb = 6'($urandom);
        end
        1: begin
          pac_valid = 0; ghost_valid = 0;
          pac_rgb = 6'($urandom); ghost_rgb = 6'($urandom); maze_rgb = 6'h3F;
        end
        default: begin
          pac_valid   = (mode == 2) ? (h == 5 && v == 3) : (h == 20 && v == 3);
          ghost_valid = pac_valid;
          pac_rgb = 6'h3C; ghost_rgb = 6'h30; maze_rgb = 6'h15;
        end
      endcase
      if (pe) begin
        pend = 1; pq = p;
        rp = pac_valid; rg = ghost_valid;
        rprgb = pac_rgb; rgrgb = ghost_rgb; rmrgb = maze_rgb;
        arm2 = (mode == 2) && h == 5 && v == 3;
        arm3 = pure3 && h == 20 && v == 3;
      end
    end
  end

  task automatic reset_checks();
    chk("rst_pix_x", pix_x, 10'd0);
    chk("rst_pix_y", pix_y, 10'd0);
    chk("rst_pix_en", pix_en, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_rgb", {r, g, b}, 6'h00);
    chk("rst_collision", collision, 1'b0);
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!frame_start && k < 2 * FT + 10);
    if (!frame_start) begin
      vecs++; errs++;
      $display("FAIL frame_timeout: got no frame_start, expected one within %0d clk", 2 * FT + 10);
    end
  endtask

  // Directed sequence of modes and resets; inputs are driven by the model process
  initial begin
    rst_n = 1; pac_valid = 0; ghost_valid = 0;
    pac_rgb = 0; ghost_rgb = 0; maze_rgb = 0;
    #2 rst_n = 0;
    #1 reset_checks();
    @(posedge clk); #7 rst_n = 1;
    repeat (3) wait_frame();
    mode = 2;
    repeat (2) wait_frame();
    mode = 3;
    repeat (2) wait_frame();
    mode = 0;
    repeat (2) wait_frame();
    repeat (2 * (5 * HT + 8)) @(posedge clk);
    #2 rst_n = 0;
    #1 reset_checks();
    @(posedge clk); #7 rst_n = 1;
    repeat (2) wait_frame();
    mode = 1;
    repeat (2) wait_frame();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
